serial_sub6: RTL

Bit-serial two's-complement subtractor: computes `diff = a - b - bin` over `WIDTH` operand bits, one bit per clock, with a start/done handshake. It is the inverse-direction companion of the team's 6-bit ripple-carry full-adder datapath. It trades the combinational adder chain for a single borrow cell plus shift registers, for area-constrained paths that can tolerate multi-cycle latency.

---
 rtl/serial_sub6.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/serial_sub6.sv
// +--------------------------------------------------------------------------+
// | Module      : serial_sub6                                                |
// | Description : Bit-serial two's-complement subtractor.                    |
// |               Computes diff = a - b - bin one bit per clock, LSB first,  |
// |               using a single borrow cell and shift registers.            |
// |               A start/done handshake frames each operation.              |
// | Build option: define SERIAL_SUB6_OVF_EN to add the signed overflow       |
// |               output 'ovf'. Without it the port and its logic are gone.  |
// | Ports       : clk   - system clock, rising edge                          |
// |               rst   - asynchronous active-high reset                     |
// |               start - request, sampled only while idle                   |
// |               a, b  - minuend / subtrahend, captured on accept           |
// |               bin   - borrow-in, captured on accept                      |
// |               busy  - operation in progress                              |
// |               done  - one-cycle pulse, result valid                      |
// |               diff  - result, held until the next accepted start         |
// |               bout  - borrow-out (a < b + bin, unsigned)                 |
// |               ovf   - signed overflow (SERIAL_SUB6_OVF_EN only)          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_sub6 #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB6_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_done;

    logic w_accept;
    logic w_last;
    logic w_ai;
    logic w_bi;
    logic w_res;
    logic w_nbr;

    // Single full-subtractor cell fed from the LSB of each operand register
    assign w_ai  = r_a[0];
    assign w_bi  = r_b[0];
    assign w_res = w_ai ^ w_bi ^ r_br;
    assign w_nbr = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

    assign w_accept = (r_state == c_IDLE) && start;
    assign w_last   = (r_state == c_RUN) && (r_cnt == c_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_nxt = c_RUN;
            c_RUN:   if (w_last) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_br  <= bin;
                r_cnt <= '0;
            end else if (r_state == c_RUN) begin
                r_a    <= r_a >> 1;
                r_b    <= r_b >> 1;
                r_br   <= w_nbr;
                // After WIDTH shifts the first result bit lands at bit 0
                r_diff <= {w_res, r_diff[WIDTH-1:1]};
                r_cnt  <= r_cnt + c_CW'(1);
                if (w_last) begin
                    r_bout <= w_nbr;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == c_RUN);
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

`ifdef SERIAL_SUB6_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep copies
    logic r_amsb;
    logic r_bmsb;
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_amsb <= a[WIDTH-1];
                r_bmsb <= b[WIDTH-1];
            end
            // The final result bit is the sign of diff
            if (w_last) begin
                r_ovf <= (r_amsb != r_bmsb) && (w_res != r_amsb);
            end
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire
